// File: rtl/pol2rec.sv
// Iterative CORDIC rotation: polar (16Q16 modulus, 8Q24 degrees) to rectangular 16Q16.
// Optional completion strobe port `done` when POL2REC_DONE_EN is defined.
module pol2rec #(
  parameter int ROMSIZE     = 32,
  parameter int COUNTERSIZE = 6,
  parameter int INSIZE      = 32,
  parameter int OUTSIZE     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  input  logic [INSIZE-1:0]   mod,
  input  logic [INSIZE-1:0]   angle,
  output logic [OUTSIZE-1:0]  x,
  output logic [OUTSIZE-1:0]  y
`ifdef POL2REC_DONE_EN
  ,
  output logic                done
`endif
);

  // state  | meaning
  // IDLE   | waiting for start, outputs hold last result
  // INIT   | gain compensation and quadrant pre-rotation
  // ITER   | one micro-rotation per cycle, ROMSIZE cycles
  // DONE   | saturate and publish x/y, drop busy
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_DONE} state_t;

  localparam int XW = INSIZE + 2;
  localparam int PW = INSIZE + 33;
  localparam logic [31:0] GAIN = 32'h4DBA76D4;
  localparam logic signed [INSIZE:0] DEG90  = (INSIZE+1)'(90)  <<< (INSIZE - 8);
  localparam logic signed [INSIZE:0] DEG180 = (INSIZE+1)'(180) <<< (INSIZE - 8);

  state_t                   r_state;
  logic signed [INSIZE-1:0] r_mod;
  logic signed [INSIZE-1:0] r_angle;
  logic signed [INSIZE-1:0] r_z;
  logic signed [XW-1:0]     r_xr;
  logic signed [XW-1:0]     r_yr;
  logic [COUNTERSIZE-1:0]   r_cnt;

  logic signed [PW-1:0]     w_mod_ext;
  logic signed [PW-1:0]     w_gain_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [XW-1:0]     w_gain;
  logic signed [INSIZE:0]   w_ang_ext;
  logic signed [INSIZE:0]   w_z_pre;
  logic                     w_flip;
  logic signed [XW-1:0]     w_xs;
  logic signed [XW-1:0]     w_ys;
  logic signed [INSIZE-1:0] w_atan;
  logic                     w_unused;

  function automatic logic [INSIZE-1:0] atan_rom(input logic [COUNTERSIZE-1:0] idx);
    logic [31:0] v;
    v = 32'h0;
    case (int'(idx))
      0:  v = 32'h2D000000;  1:  v = 32'h1A90A731;  2:  v = 32'h0E094740;  3:  v = 32'h07200112;
      4:  v = 32'h03938AA6;  5:  v = 32'h01CA3795;  6:  v = 32'h00E52A1B;  7:  v = 32'h007296D8;
      8:  v = 32'h00394BA5;  9:  v = 32'h001CA5DA;  10: v = 32'h000E52EE;  11: v = 32'h00072977;
      12: v = 32'h000394BC;  13: v = 32'h0001CA5E;  14: v = 32'h0000E52F;  15: v = 32'h00007297;
      16: v = 32'h0000394C;  17: v = 32'h00001CA6;  18: v = 32'h00000E53;  19: v = 32'h00000729;
      20: v = 32'h00000395;  21: v = 32'h000001CA;  22: v = 32'h000000E5;  23: v = 32'h00000073;
      24: v = 32'h00000039;  25: v = 32'h0000001D;  26: v = 32'h0000000E;  27: v = 32'h00000007;
      28: v = 32'h00000004;  29: v = 32'h00000002;  30: v = 32'h00000001;  31: v = 32'h00000000;
      default: v = 32'h0;
    endcase
    return INSIZE'(v);
  endfunction

  // Clamp the guarded datapath value into the signed output range.
  function automatic logic [OUTSIZE-1:0] sat(input logic signed [XW-1:0] v);
    logic [OUTSIZE-1:0] r;
    if ((&v[XW-1:OUTSIZE-1]) || !(|v[XW-1:OUTSIZE-1]))
      r = v[OUTSIZE-1:0];
    else if (v[XW-1])
      r = {1'b1, {(OUTSIZE-1){1'b0}}};
    else
      r = {1'b0, {(OUTSIZE-1){1'b1}}};
    return r;
  endfunction

  assign w_mod_ext  = {{(PW-INSIZE){r_mod[INSIZE-1]}}, r_mod};
  assign w_gain_ext = {{(PW-32){1'b0}}, GAIN};
  assign w_prod     = w_mod_ext * w_gain_ext;
  assign w_gain     = w_prod[31 +: XW];
  assign w_ang_ext  = {r_angle[INSIZE-1], r_angle};
  assign w_xs       = r_xr >>> r_cnt;
  assign w_ys       = r_yr >>> r_cnt;
  assign w_atan     = atan_rom(r_cnt);
  assign w_unused   = (^w_prod[30:0]) ^ w_z_pre[INSIZE];

  // Angles beyond +/-90 deg are folded by 180 deg; the modulus sign flip compensates.
  always_comb begin
    w_z_pre = w_ang_ext;
    w_flip  = 1'b0;
    if (w_ang_ext > DEG90) begin
      w_z_pre = w_ang_ext - DEG180;
      w_flip  = 1'b1;
    end else if (w_ang_ext < -DEG90) begin
      w_z_pre = w_ang_ext + DEG180;
      w_flip  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      x       <= '0;
      y       <= '0;
      r_mod   <= '0;
      r_angle <= '0;
      r_z     <= '0;
      r_xr    <= '0;
      r_yr    <= '0;
      r_cnt   <= '0;
`ifdef POL2REC_DONE_EN
      done    <= 1'b0;
`endif
    end else begin
`ifdef POL2REC_DONE_EN
      done <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mod   <= mod;
            r_angle <= angle;
            busy    <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_xr    <= w_flip ? -w_gain : w_gain;
          r_yr    <= '0;
          r_z     <= w_z_pre[INSIZE-1:0];
          r_cnt   <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (!r_z[INSIZE-1]) begin
            r_xr <= r_xr - w_ys;
            r_yr <= r_yr + w_xs;
            r_z  <= r_z - w_atan;
          end else begin
            r_xr <= r_xr + w_ys;
            r_yr <= r_yr - w_xs;
            r_z  <= r_z + w_atan;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == COUNTERSIZE'(ROMSIZE - 1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          x       <= sat(r_xr);
          y       <= sat(r_yr);
          busy    <= 1'b0;
`ifdef POL2REC_DONE_EN
          done    <= 1'b1;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pol2rec.sv
// Self-checking bench for pol2rec: scoreboard of expected x/y, latency and handshake checks.
module tb_pol2rec;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic [31:0] mod;
  logic [31:0] angle;
  logic [31:0] x;
  logic [31:0] y;
`ifdef POL2REC_DONE_EN
  logic        done;
  int          done_cnt = 0;
`endif

  typedef struct {
    int    ex;
    int    ey;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_runs = 0;
  localparam int  TOL  = 8;
  localparam int  LAT  = 34;
  localparam real PI   = 3.14159265358979;

  pol2rec dut (
    .clock(clk),
    .reset(rst),
    .start(start),
    .busy(busy),
    .mod(mod),
    .angle(angle),
    .x(x),
    .y(y)
`ifdef POL2REC_DONE_EN
    ,
    .done(done)
`endif
  );

  always #5 clk = ~clk;

`ifdef POL2REC_DONE_EN
  always @(negedge clk) if (done === 1'b1) done_cnt++;
`endif

  task automatic launch(input logic [31:0] m, input logic [31:0] a, input int ex, input int ey,
                        input string nm);
    exp_t e;
    @(negedge clk);
    mod = m; angle = a; start = 1'b1;
    e.ex = ex; e.ey = ey; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; mod = $urandom; angle = $urandom;
  endtask

  // Counts busy cycles from the first negedge after the start edge until busy drops.
  task automatic wait_done(input int pre, output int cyc, output logic dn);
    cyc = pre;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc < 200) n_runs++;
`ifdef POL2REC_DONE_EN
    dn = done;
`else
    dn = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mod = '0; angle = '0;
    #1 rst = 1'b1;
    #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (x !== 32'h0) begin n_err++; $display("FAIL reset_x got=%h want=0", x); end
    n_vec++; if (y !== 32'h0) begin n_err++; $display("FAIL reset_y got=%h want=0", y); end
`ifdef POL2REC_DONE_EN
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
`endif
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] mv[4] = '{32'h00010000, 32'h00010000, 32'h00020000, 32'h00010000};
    logic [31:0] av[4] = '{32'h00000000, 32'h5A000000, 32'hD3000000, 32'h78000000};
    logic [31:0] xv[4] = '{32'h00010000, 32'h00000000, 32'h00016A0A, 32'hFFFF8000};
    logic [31:0] yv[4] = '{32'h00000000, 32'h00010000, 32'hFFFE95F6, 32'h0000DDB4};
    int cyc, dx, dy;
    logic dn;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      launch(mv[i], av[i], $signed(xv[i]), $signed(yv[i]), $sformatf("basic%0d", i));
      wait_done(0, cyc, dn);
      e = sb.pop_front();
      dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
      n_vec++; if (cyc != LAT) begin n_err++; $display("FAIL %s_busy_cycles got=%0d want=%0d", e.nm, cyc, LAT); end
      n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL %s_x got=%h want=%h", e.nm, x, e.ex); end
      n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL %s_y got=%h want=%h", e.nm, y, e.ey); end
`ifdef POL2REC_DONE_EN
      n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL %s_done got=%b want=1", e.nm, dn); end
`endif
      @(negedge clk);
`ifdef POL2REC_DONE_EN
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_width got=%b want=0", e.nm, done); end
`endif
    end
  endtask

  // 2.0 at 60 deg, with a second start 5 cycles in that must be ignored.
  task automatic test_ignore_start();
    int cyc, dx, dy;
    logic dn;
    exp_t e;
    launch(32'h00020000, 32'h3C000000, 65536, 113512, "ignore");
    repeat (4) @(negedge clk);
    start = 1'b1; mod = 32'h00050000; angle = 32'h87000000;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc, dn);
    e = sb.pop_front();
    dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
    n_vec++; if (cyc != LAT) begin n_err++; $display("FAIL ignore_busy_cycles got=%0d want=%0d", cyc, LAT); end
    n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL ignore_x got=%h want=%h", x, e.ex); end
    n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL ignore_y got=%h want=%h", y, e.ey); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart got=%b want=0", busy); end
  endtask

  task automatic test_done_window();
    int cyc, dx, dy;
    exp_t e;
    launch(32'h00010000, 32'h1E000000, 56756, 32768, "donewin");
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = (cyc == LAT);
      if (start) begin mod = 32'h00030000; angle = 32'h00000000; end
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc < 200) n_runs++;
    e = sb.pop_front();
    dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
    n_vec++; if (cyc != LAT) begin n_err++; $display("FAIL donewin_busy_cycles got=%0d want=%0d", cyc, LAT); end
    n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL donewin_x got=%h want=%h", x, e.ex); end
    n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL donewin_y got=%h want=%h", y, e.ey); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL donewin_start_ignored got=%b want=0", busy); end
  endtask

  // Second run launched in the first IDLE cycle; old result must hold meanwhile.
  task automatic test_back_to_back();
    int cyc, dx, dy;
    logic dn;
    exp_t e;
    launch(32'h00010000, 32'hD3000000, 46341, -46341, "b2b_a");
    wait_done(0, cyc, dn);
    e = sb.pop_front();
    launch(32'h00008000, 32'h5A000000, 0, 32768, "b2b_b");
    repeat (10) @(negedge clk);
    dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b want=1", busy); end
    n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL b2b_hold_x got=%h want=%h", x, e.ex); end
    n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL b2b_hold_y got=%h want=%h", y, e.ey); end
    wait_done(10, cyc, dn);
    e = sb.pop_front();
    dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
    n_vec++; if (cyc != LAT) begin n_err++; $display("FAIL b2b_busy_cycles got=%0d want=%0d", cyc, LAT); end
    n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL b2b_x got=%h want=%h", x, e.ex); end
    n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL b2b_y got=%h want=%h", y, e.ey); end
  endtask

  task automatic test_reset_mid();
    int cyc, dx, dy;
    logic dn;
    exp_t e;
    launch(32'h00010000, 32'h1E000000, 0, 0, "aborted");
    e = sb.pop_front();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_vec++; if (x !== 32'h0) begin n_err++; $display("FAIL midrst_x got=%h want=0", x); end
    n_vec++; if (y !== 32'h0) begin n_err++; $display("FAIL midrst_y got=%h want=0", y); end
    @(negedge clk); rst = 1'b0;
    launch(32'h00010000, 32'hE2000000, 56756, -32768, "postrst");
    wait_done(0, cyc, dn);
    e = sb.pop_front();
    dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
    n_vec++; if (cyc != LAT) begin n_err++; $display("FAIL postrst_busy_cycles got=%0d want=%0d", cyc, LAT); end
    n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL postrst_x got=%h want=%h", x, e.ex); end
    n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL postrst_y got=%h want=%h", y, e.ey); end
`ifdef POL2REC_DONE_EN
    n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL postrst_done got=%b want=1", dn); end
`endif
  endtask

  // Expected values from real-valued trigonometry, incl. -90 and fold boundaries.
  task automatic test_sweep();
    real ms[5] = '{1.5, 0.75, 3.0, 1.0, 2.5};
    real ds[5] = '{30.0, -120.0, 100.0, -90.0, 127.5};
    int cyc, dx, dy;
    logic dn;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      launch(32'(int'(ms[i] * 65536.0)), 32'(int'(ds[i] * 16777216.0)),
             int'(ms[i] * $cos(ds[i] * PI / 180.0) * 65536.0),
             int'(ms[i] * $sin(ds[i] * PI / 180.0) * 65536.0), $sformatf("sweep%0d", i));
      wait_done(0, cyc, dn);
      e = sb.pop_front();
      dx = $signed(x) - e.ex; dy = $signed(y) - e.ey;
      n_vec++; if (dx > TOL || dx < -TOL) begin n_err++; $display("FAIL %s_x got=%h want=%h", e.nm, x, e.ex); end
      n_vec++; if (dy > TOL || dy < -TOL) begin n_err++; $display("FAIL %s_y got=%h want=%h", e.nm, y, e.ey); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_done_window();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    repeat (2) @(negedge clk);
`ifdef POL2REC_DONE_EN
    n_vec++; if (done_cnt != n_runs) begin n_err++; $display("FAIL done_pulse_count got=%0d want=%0d", done_cnt, n_runs); end
`endif
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
